// File: rtl/rtc_bus_sequencer_pkg.sv
// Shared types and defaults for the RTC parallel-bus sequencer.
// Holds the FSM state encoding, the default phase lengths and the idle pin levels.
package rtc_bus_sequencer_pkg;

  localparam int unsigned TIMER_W   = 9;
  localparam int unsigned T_ALE_DEF = 10;
  localparam int unsigned T_AH_DEF  = 5;
  localparam int unsigned T_STB_DEF = 15;
  localparam int unsigned T_REC_DEF = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_HOLD,
    ST_STROBE,
    ST_RECOVER,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic       ale;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       ad_oe;
    logic [7:0] ad_out;
  } bus_pins_t;

  localparam bus_pins_t PINS_IDLE = '{
    ale:    1'b0,
    cs_n:   1'b1,
    rd_n:   1'b1,
    wr_n:   1'b1,
    ad_oe:  1'b0,
    ad_out: 8'h00
  };

endpackage

// File: rtl/rtc_bus_sequencer_timer.sv
// Shared phase timer: up-counter with synchronous clear and enable.
// term flags the last cycle of a phase whose length is limit cycles.
module bus_phase_timer
  import rtc_bus_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               en,
  input  logic [TIMER_W-1:0] limit,
  output logic               term
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + TIMER_W'(1);
    end
  end

  // A limit of 511 terminates at 510, so the counter never wraps.
  assign term = (count == (limit - TIMER_W'(1)));

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Sequences one address/strobe/recovery transaction on the multiplexed RTC bus.
// All pins are registered from the next state so they are valid on the first cycle of each state.
module rtc_bus_sequencer
  import rtc_bus_sequencer_pkg::*;
#(
  parameter int unsigned T_ALE = T_ALE_DEF,
  parameter int unsigned T_AH  = T_AH_DEF,
  parameter int unsigned T_STB = T_STB_DEF,
  parameter int unsigned T_REC = T_REC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       wr,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in,
  output logic       ale,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n
);

  localparam logic [TIMER_W-1:0] LIM_ALE = TIMER_W'(T_ALE);
  localparam logic [TIMER_W-1:0] LIM_AH  = TIMER_W'(T_AH);
  localparam logic [TIMER_W-1:0] LIM_STB = TIMER_W'(T_STB);
  localparam logic [TIMER_W-1:0] LIM_REC = TIMER_W'(T_REC);

  state_t             state_q, state_d;
  logic               wr_q;
  logic [7:0]         addr_q, wdata_q;
  logic               cur_wr;
  logic [7:0]         cur_addr, cur_wdata;
  logic               tmr_clr, tmr_en, tmr_term;
  logic [TIMER_W-1:0] tmr_limit;
  bus_pins_t          pins_d, pins_q;
  logic               done_q;
  logic [7:0]         rdata_q;

  bus_phase_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .limit (tmr_limit),
    .term  (tmr_term)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (req)      state_d = ST_ADDR;
      ST_ADDR:    if (tmr_term) state_d = ST_HOLD;
      ST_HOLD:    if (tmr_term) state_d = ST_STROBE;
      ST_STROBE:  if (tmr_term) state_d = ST_RECOVER;
      ST_RECOVER: if (tmr_term) state_d = ST_DONE;
      ST_DONE:                  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tmr_limit = TIMER_W'(1);
    tmr_en    = 1'b1;
    unique case (state_q)
      ST_ADDR:    tmr_limit = LIM_ALE;
      ST_HOLD:    tmr_limit = LIM_AH;
      ST_STROBE:  tmr_limit = LIM_STB;
      ST_RECOVER: tmr_limit = LIM_REC;
      default:    tmr_en    = 1'b0;
    endcase
    tmr_clr = (state_d != state_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state_q == ST_IDLE && req) begin
      wr_q    <= wr;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // On the accepting edge the request fields are not latched yet, so take them from the inputs.
  always_comb begin
    cur_wr    = (state_q == ST_IDLE) ? wr    : wr_q;
    cur_addr  = (state_q == ST_IDLE) ? addr  : addr_q;
    cur_wdata = (state_q == ST_IDLE) ? wdata : wdata_q;
  end

  always_comb begin
    pins_d = PINS_IDLE;
    unique case (state_d)
      ST_ADDR: begin
        pins_d.ale    = 1'b1;
        pins_d.ad_oe  = 1'b1;
        pins_d.ad_out = cur_addr;
      end
      ST_HOLD: begin
        pins_d.ad_oe  = 1'b1;
        pins_d.ad_out = cur_addr;
      end
      ST_STROBE: begin
        pins_d.cs_n = 1'b0;
        if (cur_wr) begin
          pins_d.wr_n   = 1'b0;
          pins_d.ad_oe  = 1'b1;
          pins_d.ad_out = cur_wdata;
        end else begin
          pins_d.rd_n = 1'b0;
        end
      end
      ST_RECOVER: begin
        if (cur_wr) begin
          pins_d.ad_oe  = 1'b1;
          pins_d.ad_out = cur_wdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pins_q <= PINS_IDLE;
      done_q <= 1'b0;
    end else begin
      pins_q <= pins_d;
      done_q <= (state_d == ST_DONE);
    end
  end

  // Capture on the edge where rd_n rises (last STROBE cycle of a read).
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (state_q == ST_STROBE && state_d == ST_RECOVER && !wr_q) begin
      rdata_q <= ad_in;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign rdata  = rdata_q;
  assign ale    = pins_q.ale;
  assign cs_n   = pins_q.cs_n;
  assign rd_n   = pins_q.rd_n;
  assign wr_n   = pins_q.wr_n;
  assign ad_oe  = pins_q.ad_oe;
  assign ad_out = pins_q.ad_out;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Scoreboard bench for rtc_bus_sequencer: stimulus queues expected transactions,
// a negedge monitor checks pin timelines, latency, gaps and rdata.
module tb_rtc_bus_sequencer;

  localparam int TA = 10, TH = 5, TS = 15, TR = 10;
  localparam int TOTAL = TA + TH + TS + TR;
  localparam logic [12:0] IDLE_VEC = {5'b01110, 8'h00};

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         gap;
  } item_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0, req1 = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] addr = 8'h00, wdata = 8'h00;
  logic [7:0] ad_in = 8'h00;
  logic [7:0] rd_val = 8'h00, rd_val1 = 8'h00;

  logic       busy, done, ad_oe, ale, cs_n, rd_n, wr_n;
  logic [7:0] rdata, ad_out;
  logic       busy1, done1, ad_oe1, ale1, cs_n1, rd_n1, wr_n1;
  logic [7:0] rdata1, ad_out1;
  logic [12:0] pins, pins1;

  int    errors = 0;
  int    checks = 0;
  item_t sbq[$];
  item_t cur;
  bit    active = 0;
  bit    mon_en = 1;
  int    cyc = 0;
  int    idle_cnt = -1;

  always #5 clk = ~clk;

  rtc_bus_sequencer dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .ad_out(ad_out), .ad_oe(ad_oe),
    .ad_in(ad_in), .ale(ale), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n)
  );

  rtc_bus_sequencer #(.T_ALE(1), .T_AH(1), .T_STB(1), .T_REC(1)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .wr(wr), .addr(addr), .wdata(wdata),
    .busy(busy1), .done(done1), .rdata(rdata1), .ad_out(ad_out1), .ad_oe(ad_oe1),
    .ad_in(ad_in), .ale(ale1), .cs_n(cs_n1), .rd_n(rd_n1), .wr_n(wr_n1)
  );

  assign pins  = {ale,  cs_n,  rd_n,  wr_n,  ad_oe,  ad_oe  ? ad_out  : 8'h00};
  assign pins1 = {ale1, cs_n1, rd_n1, wr_n1, ad_oe1, ad_oe1 ? ad_out1 : 8'h00};

  // RTC model: drives read data only while rd_n is low.
  always @(negedge clk) begin
    ad_in = !rd_n ? rd_val : (!rd_n1 ? rd_val1 : 8'h00);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] exp_pins(input item_t it, input int c,
                                           input int a, input int h, input int s, input int r);
    if (c < a)                 return {5'b11111, it.addr};
    else if (c < a + h)        return {5'b01111, it.addr};
    else if (c < a + h + s)    return it.wr ? {5'b00101, it.wdata} : {5'b00010, 8'h00};
    else if (c < a + h + s + r) return it.wr ? {5'b01111, it.wdata} : {5'b01110, 8'h00};
    else                       return IDLE_VEC;
  endfunction

  always @(negedge clk) begin
    if (reset || !mon_en) begin
      active   = 0;
      idle_cnt = -1;
    end else if (!busy) begin
      if (active) begin
        checks++; errors++;
        $display("FAIL busy_early: busy 0 at cycle %0d, required 1", cyc);
        active = 0;
      end
      check("done_idle", done, 0);
      if (idle_cnt >= 0) idle_cnt++;
    end else begin
      if (!active) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_busy: busy 1 with no pending request, required 0");
        end else begin
          cur    = sbq.pop_front();
          active = 1;
          cyc    = 0;
          if (cur.gap >= 0) check("gap", idle_cnt, cur.gap);
        end
      end
      if (active) begin
        check("pins", pins, exp_pins(cur, cyc, TA, TH, TS, TR));
        check("done", done, cyc == TOTAL);
        if (cyc == TOTAL) begin
          check("rdata", rdata, cur.rdata);
          active   = 0;
          idle_cnt = 0;
        end
        cyc++;
      end
    end
  end

  task automatic push(input logic w, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] rd, input int g);
    item_t it;
    it.wr = w; it.addr = a; it.wdata = d; it.rdata = rd; it.gap = g;
    sbq.push_back(it);
  endtask

  // Fields are scrambled after acceptance to prove they were latched.
  task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    wr = w; addr = a; wdata = d; req = 1'b1;
    @(negedge clk);
    req = 1'b0; wr = ~w; addr = 8'hFF; wdata = 8'h00;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(sbq.size() == 0 && !active && !busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL wait_idle: transaction still pending after %0d cycles, required done", n);
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    item_t t1;
    int n;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("reset_pins", pins, IDLE_VEC);
      check("reset_state", {busy, done, rdata}, 10'h000);
    end

    // Reset during STROBE cycle 7 of a read: pins idle next cycle, no done.
    mon_en = 0;
    rd_val = 8'h77;
    issue(1'b0, 8'h33, 8'h00);
    repeat (21) @(negedge clk);
    check("abort_in_strobe", {cs_n, rd_n}, 2'b00);
    reset = 1'b1;
    @(negedge clk);
    check("abort_pins", pins, IDLE_VEC);
    check("abort_state", {busy, done, rdata}, 10'h000);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_no_done", {busy, done}, 2'b00);
    end
    mon_en = 1;

    push(1'b1, 8'h21, 8'h59, 8'h00, -1);
    issue(1'b1, 8'h21, 8'h59);
    wait_idle();

    rd_val = 8'hA5;
    push(1'b0, 8'h22, 8'h00, 8'hA5, -1);
    issue(1'b0, 8'h22, 8'h00);
    wait_idle();

    push(1'b1, 8'h30, 8'h11, 8'hA5, -1);
    issue(1'b1, 8'h30, 8'h11);
    wait_idle();

    // req held high: one IDLE cycle between transactions, nothing accepted while busy.
    rd_val = 8'h3C;
    push(1'b0, 8'h40, 8'h00, 8'h3C, -1);
    push(1'b0, 8'h40, 8'h00, 8'h3C, 1);
    push(1'b0, 8'h40, 8'h00, 8'h3C, 1);
    @(negedge clk);
    wr = 1'b0; addr = 8'h40; wdata = 8'h00; req = 1'b1;
    n = 0;
    while (!(sbq.size() == 0 && active) && n < 300) begin
      @(negedge clk);
      n++;
    end
    req = 1'b0;
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL b2b_wait: third transaction not started after %0d cycles", n);
    end
    wait_idle();

    // All phases of length 1: done 4 edges after acceptance.
    for (int k = 0; k < 2; k++) begin
      t1.wr = (k == 0); t1.addr = 8'h55 + 8'(k); t1.wdata = 8'h6A; t1.rdata = 8'h3C; t1.gap = -1;
      rd_val1 = 8'h3C;
      @(negedge clk);
      wr = t1.wr; addr = t1.addr; wdata = t1.wdata; req1 = 1'b1;
      @(negedge clk);
      req1 = 1'b0; addr = 8'hFF; wdata = 8'h00; wr = ~t1.wr;
      for (int i = 0; i < 6; i++) begin
        check("t1_pins", pins1, exp_pins(t1, i, 1, 1, 1, 1));
        check("t1_done", done1, i == 4);
        if (i == 4 && k == 1) check("t1_rdata", rdata1, 8'h3C);
        @(negedge clk);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
